// File: rtl/adc124_sampler.sv
// ADC124S021 4-channel sampler: five 16-bit SPI frames per acquisition, results latched together.
// Define ADC124_OFFSET_EN to output two's-complement codes about mid-scale instead of raw codes.
module adc124_sampler #(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStart,
    input  logic        iADC124_MISO,
    output logic        oADC124_CS_n,
    output logic        oADC124_SCLK,
    output logic        oADC124_MOSI,
    output logic [11:0] oCh0,
    output logic [11:0] oCh1,
    output logic [11:0] oCh2,
    output logic [11:0] oCh3,
    output logic        oBusy,
    output logic        oDone
);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

    localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
    localparam logic [6:0] PerLast = 7'd79;
`ifdef ADC124_OFFSET_EN
    localparam logic [11:0] CodeXor = 12'h800;
`else
    localparam logic [11:0] CodeXor = 12'h000;
`endif

    state_e      stateQ, stateD;
    logic [7:0]  divCntQ, divCntD;
    logic [6:0]  perCntQ, perCntD;
    logic        sclkQ, sclkD;
    logic        csNQ, csND;
    logic        mosiQ, mosiD;
    logic        busyQ, busyD;
    logic        doneQ, doneD;
    logic [11:0] shiftQ, shiftD;
    logic [11:0] cap0Q, cap0D, cap1Q, cap1D, cap2Q, cap2D;
    logic [11:0] ch0Q, ch0D, ch1Q, ch1D, ch2Q, ch2D, ch3Q, ch3D;

    logic [11:0] shiftIn;
    logic [3:0]  bitPos;
    logic [2:0]  frameIdx;

    assign shiftIn  = {shiftQ[10:0], iADC124_MISO};
    assign bitPos   = perCntQ[3:0];
    assign frameIdx = perCntQ[6:4];

    // Frame bit for SCLK period 'per': address on bits 13..11, frame 4 re-addresses IN0.
    function automatic logic mosiBit(input logic [6:0] per);
        logic [2:0] addr;
        addr = (per[6:4] == 3'd4) ? 3'd0 : per[6:4];
        case (per[3:0])
            4'd2:    mosiBit = addr[2];
            4'd3:    mosiBit = addr[1];
            4'd4:    mosiBit = addr[0];
            default: mosiBit = 1'b0;
        endcase
    endfunction

    always_comb begin
        stateD  = stateQ;
        divCntD = divCntQ;
        perCntD = perCntQ;
        sclkD   = sclkQ;
        csND    = csNQ;
        mosiD   = mosiQ;
        busyD   = busyQ;
        doneD   = 1'b0;
        shiftD  = shiftQ;
        cap0D   = cap0Q;
        cap1D   = cap1Q;
        cap2D   = cap2Q;
        ch0D    = ch0Q;
        ch1D    = ch1Q;
        ch2D    = ch2Q;
        ch3D    = ch3Q;

        unique case (stateQ)
            StIdle: begin
                if (iStart) begin
                    stateD  = StSetup;
                    csND    = 1'b0;
                    busyD   = 1'b1;
                    sclkD   = 1'b1;
                    divCntD = 8'd0;
                end
            end
            StSetup: begin
                if (divCntQ == DivLast) begin
                    stateD  = StShift;
                    divCntD = 8'd0;
                    perCntD = 7'd0;
                    sclkD   = 1'b0;
                    mosiD   = mosiBit(7'd0);
                end else begin
                    divCntD = divCntQ + 8'd1;
                end
            end
            StShift: begin
                if (divCntQ != DivLast) begin
                    divCntD = divCntQ + 8'd1;
                end else if (!sclkQ) begin
                    // Rising SCLK: sample MISO, keep only the 12 data bits of each frame.
                    divCntD = 8'd0;
                    sclkD   = 1'b1;
                    if (bitPos >= 4'd4) begin
                        shiftD = shiftIn;
                    end
                    if (bitPos == 4'd15) begin
                        case (frameIdx)
                            3'd1:    cap0D = shiftIn;
                            3'd2:    cap1D = shiftIn;
                            3'd3:    cap2D = shiftIn;
                            default: ;
                        endcase
                    end
                end else if (perCntQ == PerLast) begin
                    stateD  = StHold;
                    divCntD = 8'd0;
                end else begin
                    divCntD = 8'd0;
                    perCntD = perCntQ + 7'd1;
                    sclkD   = 1'b0;
                    mosiD   = mosiBit(perCntQ + 7'd1);
                end
            end
            StHold: begin
                if (divCntQ == DivLast) begin
                    stateD  = StIdle;
                    divCntD = 8'd0;
                    perCntD = 7'd0;
                    csND    = 1'b1;
                    busyD   = 1'b0;
                    doneD   = 1'b1;
                    mosiD   = 1'b0;
                    ch0D    = cap0Q ^ CodeXor;
                    ch1D    = cap1Q ^ CodeXor;
                    ch2D    = cap2Q ^ CodeXor;
                    ch3D    = shiftQ ^ CodeXor;
                end else begin
                    divCntD = divCntQ + 8'd1;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stateQ  <= StIdle;
            divCntQ <= 8'd0;
            perCntQ <= 7'd0;
            sclkQ   <= 1'b1;
            csNQ    <= 1'b1;
            mosiQ   <= 1'b0;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
            shiftQ  <= 12'd0;
            cap0Q   <= 12'd0;
            cap1Q   <= 12'd0;
            cap2Q   <= 12'd0;
            ch0Q    <= 12'd0;
            ch1Q    <= 12'd0;
            ch2Q    <= 12'd0;
            ch3Q    <= 12'd0;
        end else begin
            stateQ  <= stateD;
            divCntQ <= divCntD;
            perCntQ <= perCntD;
            sclkQ   <= sclkD;
            csNQ    <= csND;
            mosiQ   <= mosiD;
            busyQ   <= busyD;
            doneQ   <= doneD;
            shiftQ  <= shiftD;
            cap0Q   <= cap0D;
            cap1Q   <= cap1D;
            cap2Q   <= cap2D;
            ch0Q    <= ch0D;
            ch1Q    <= ch1D;
            ch2Q    <= ch2D;
            ch3Q    <= ch3D;
        end
    end

    assign oADC124_CS_n = csNQ;
    assign oADC124_SCLK = sclkQ;
    assign oADC124_MOSI = mosiQ;
    assign oBusy        = busyQ;
    assign oDone        = doneQ;
    assign oCh0         = ch0Q;
    assign oCh1         = ch1Q;
    assign oCh2         = ch2Q;
    assign oCh3         = ch3Q;

endmodule

// File: tb/tb_adc124_sampler.sv
// Directed bench for adc124_sampler with a behavioural ADC124S021 model.
module tb_adc124_sampler;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iStart;
    logic        iADC124_MISO;
    logic        oADC124_CS_n;
    logic        oADC124_SCLK;
    logic        oADC124_MOSI;
    logic [11:0] oCh0, oCh1, oCh2, oCh3;
    logic        oBusy;
    logic        oDone;

    adc124_sampler dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iStart       (iStart),
        .iADC124_MISO (iADC124_MISO),
        .oADC124_CS_n (oADC124_CS_n),
        .oADC124_SCLK (oADC124_SCLK),
        .oADC124_MOSI (oADC124_MOSI),
        .oCh0         (oCh0),
        .oCh1         (oCh1),
        .oCh2         (oCh2),
        .oCh3         (oCh3),
        .oBusy        (oBusy),
        .oDone        (oDone)
    );

    always #5 iClk = ~iClk;

`ifdef ADC124_OFFSET_EN
    localparam logic [11:0] ExpXor = 12'h800;
`else
    localparam logic [11:0] ExpXor = 12'h000;
`endif

    int nChecks = 0;
    int nErrors = 0;
    int cyc = 0;

    always @(posedge iClk) cyc = cyc + 1;

    // ADC model: decodes DIN on rising SCLK, answers with the addressed channel in the next frame.
    logic [11:0] modelVal [4];
    logic [15:0] dinShift;
    logic [11:0] curData;
    logic        misoReg = 1'b0;
    logic        prevSclk = 1'b1;
    logic        prevCs = 1'b1;
    int          riseCnt = 0;
    int          addrCnt = 0;
    int          addrLog [5];
    int          rise0Cyc = 0;
    int          rise1Cyc = 0;
    int          csGlitch = 0;

    assign iADC124_MISO = misoReg;

    always @(negedge iClk) begin
        int idx;
        logic [2:0] addr;
        if (oBusy && oADC124_CS_n) csGlitch++;
        if (prevCs && !oADC124_CS_n) begin
            riseCnt  = 0;
            addrCnt  = 0;
            dinShift = 16'd0;
            curData  = modelVal[0];
        end
        if (!oADC124_CS_n && !prevSclk && oADC124_SCLK) begin
            dinShift = {dinShift[14:0], oADC124_MOSI};
            riseCnt++;
            if (riseCnt == 1) rise0Cyc = cyc;
            if (riseCnt == 2) rise1Cyc = cyc;
            if (riseCnt % 16 == 0) begin
                addr = dinShift[13:11];
                if (addrCnt < 5) addrLog[addrCnt] = int'(addr);
                addrCnt++;
                curData = modelVal[addr[1:0]];
            end
        end
        if (!oADC124_CS_n && prevSclk && !oADC124_SCLK) begin
            idx = riseCnt % 16;
            misoReg = (idx >= 4) ? curData[15-idx] : 1'b0;
        end
        prevSclk = oADC124_SCLK;
        prevCs   = oADC124_CS_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int lat, busyLow, holdBad;

    task automatic runAcq(input int p1, input int p2, input logic [47:0] prevExp);
        @(negedge iClk) iStart = 1'b1;
        @(posedge iClk);
        #1 iStart = 1'b0;
        check("accept_busy", oBusy, 1);
        check("accept_cs", oADC124_CS_n, 0);
        lat = 0;
        busyLow = 0;
        holdBad = 0;
        while (lat < 2000) begin
            @(posedge iClk);
            #1 lat++;
            if (oDone) break;
            if (!oBusy) busyLow++;
            if ({oCh0, oCh1, oCh2, oCh3} !== prevExp) holdBad++;
            iStart = (lat == p1 || lat == p2);
        end
        iStart = 1'b0;
        check("done_busy_low", oBusy, 0);
        check("done_cs_high", oADC124_CS_n, 1);
    endtask

    task automatic checkResult(input logic [11:0] e0, input logic [11:0] e1,
                               input logic [11:0] e2, input logic [11:0] e3);
        check("latency", lat, 810);
        check("busy_held", busyLow, 0);
        check("ch_hold", holdBad, 0);
        check("ch0", oCh0, e0);
        check("ch1", oCh1, e1);
        check("ch2", oCh2, e2);
        check("ch3", oCh3, e3);
        check("frames", addrCnt, 5);
        check("addr0", addrLog[0], 0);
        check("addr1", addrLog[1], 1);
        check("addr2", addrLog[2], 2);
        check("addr3", addrLog[3], 3);
        check("addr4", addrLog[4], 0);
        check("sclk_rises", riseCnt, 80);
        check("sclk_period", rise1Cyc - rise0Cyc, 10);
        check("cs_continuous", csGlitch, 0);
    endtask

    initial begin
        int k, csHigh, csFallK, dones;

        iRst = 1'b1;
        iStart = 1'b0;
`ifdef ADC124_OFFSET_EN
        modelVal[0] = 12'h800; modelVal[1] = 12'h000; modelVal[2] = 12'hFFF; modelVal[3] = 12'h801;
`else
        modelVal[0] = 12'h123; modelVal[1] = 12'h456; modelVal[2] = 12'h789; modelVal[3] = 12'hABC;
`endif
        repeat (3) @(posedge iClk);
        #1;
        check("rst_cs", oADC124_CS_n, 1);
        check("rst_sclk", oADC124_SCLK, 1);
        check("rst_mosi", oADC124_MOSI, 0);
        check("rst_busy", oBusy, 0);
        check("rst_done", oDone, 0);
        check("rst_ch", {oCh0, oCh1, oCh2, oCh3}, 0);
        @(negedge iClk) iRst = 1'b0;
        repeat (5) @(posedge iClk);

        // Plain acquisition.
        runAcq(-1, -1, 48'd0);
`ifdef ADC124_OFFSET_EN
        checkResult(12'h000, 12'h800, 12'h7FF, 12'h001);
`else
        checkResult(12'h123, 12'h456, 12'h789, 12'hABC);
`endif

        // iStart pulses while busy are ignored; previous results must hold throughout.
        modelVal[0] = 12'hFFF; modelVal[1] = 12'h000; modelVal[2] = 12'h5A5; modelVal[3] = 12'h3C3;
`ifdef ADC124_OFFSET_EN
        runAcq(100, 400, {12'h000, 12'h800, 12'h7FF, 12'h001});
`else
        runAcq(100, 400, {12'h123, 12'h456, 12'h789, 12'hABC});
`endif
        checkResult(12'hFFF ^ ExpXor, 12'h000 ^ ExpXor, 12'h5A5 ^ ExpXor, 12'h3C3 ^ ExpXor);
        dones = 0;
        repeat (900) begin
            @(posedge iClk);
            #1 if (oDone || !oADC124_CS_n) dones++;
        end
        check("no_extra_acq", dones, 0);

        // Reset during frame 2 aborts the acquisition.
        modelVal[0] = 12'h0F0; modelVal[1] = 12'hE01; modelVal[2] = 12'h7FE; modelVal[3] = 12'h10A;
        @(negedge iClk) iStart = 1'b1;
        @(posedge iClk);
        #1 iStart = 1'b0;
        repeat (399) @(posedge iClk);
        #1 iRst = 1'b1;
        #1;
        check("abort_cs", oADC124_CS_n, 1);
        check("abort_sclk", oADC124_SCLK, 1);
        check("abort_mosi", oADC124_MOSI, 0);
        check("abort_busy", oBusy, 0);
        check("abort_ch", {oCh0, oCh1, oCh2, oCh3}, 0);
        repeat (3) @(posedge iClk);
        @(negedge iClk) iRst = 1'b0;
        dones = 0;
        repeat (1000) begin
            @(posedge iClk);
            #1 if (oDone) dones++;
        end
        check("abort_no_done", dones, 0);
        runAcq(-1, -1, 48'd0);
        checkResult(12'h0F0 ^ ExpXor, 12'hE01 ^ ExpXor, 12'h7FE ^ ExpXor, 12'h10A ^ ExpXor);

        // iStart held high: back-to-back acquisitions, CS_n high for one cycle in between.
        @(negedge iClk) iStart = 1'b1;
        k = 0;
        while (k < 2000) begin
            @(posedge iClk);
            #1 k++;
            if (oDone) break;
        end
        check("b2b_first_done", k, 811);
        csHigh = oADC124_CS_n ? 1 : 0;
        csFallK = -1;
        k = 0;
        while (k < 2000) begin
            @(posedge iClk);
            #1 k++;
            if (oDone) break;
            if (oADC124_CS_n) csHigh++;
            else if (csFallK < 0) csFallK = k;
        end
        iStart = 1'b0;
        check("b2b_cs_high_cycles", csHigh, 1);
        check("b2b_restart_edge", csFallK, 1);
        check("b2b_latency", k - csFallK, 810);
        check("b2b_ch0", oCh0, 12'h0F0 ^ ExpXor);
        check("b2b_ch3", oCh3, 12'h10A ^ ExpXor);
        repeat (3) @(posedge iClk);
        #1 check("b2b_stops", oBusy, 0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
